mdu_iter: RTL
=============

// Module: mdu_iter
// PURPOSE
//  Iterative, parametrised multiply/divide unit with architectural HI/LO registers.
//  It implements mult, multu, div, divu, mfhi, mthi, mflo and mtlo.
//  Each mult/div retires one bit per cycle, so area stays small, and the unit exposes busy/done for pipeline stalls.
//  It sits beside the ALU in EX. It supports abort for exception flush.
// PARAMETERS
//  WIDTH   32   operand width, and width of HI and LO (legal: 4..64)
//  CNT_W   $clog2(WIDTH)+1   iteration counter width (derived; do not override)
// PORTS
//  clk     in   1      rising-edge clock
//  rst_n   in   1      synchronous active-low reset
//  start   in   1      issue the op on op/src_a/src_b; accepted only when busy=0
//  op      in   3      000 mult, 001 multu, 010 div, 011 divu, 100 mfhi, 101 mthi, 110 mflo, 111 mtlo
//  src_a   in   WIDTH  rs operand (dividend / multiplicand / mthi-mtlo data)
//  src_b   in   WIDTH  rt operand (divisor / multiplier)
//  abort   in   1      kill the in-flight mult/div; HI/LO are not updated
//  busy    out  1      mult/div in progress; the pipeline must stall on MDU ops
//  done    out  1      one-cycle pulse: HI/LO just updated by mult/div
//  res     out  WIDTH  read data: op[1] ? LO : HI (combinational from the registers)
// BEHAVIOUR
//  Reset (rst_n=0 at the clock edge):
//   - HI=LO=0, state=IDLE, busy=0, done=0, counter=0.
//   - Reset overrides start and abort, and reset mid-operation discards the operation.
//  FSM states:
//   - IDLE: start=1 with op 00x/01x -> RUN; operands captured, counter=WIDTH.
//   - IDLE: start=1 with mthi or mtlo writes HI or LO <= src_a at that edge; no busy, no done.
//   - IDLE: start=1 with mfhi or mflo causes no state change.
//   - RUN: one shift-add (mul) or restoring-subtract (div) step per cycle, counter-1.
//   - RUN: when counter reaches 1 -> FIX.
//   - FIX: sign correction; HI/LO written at the end of FIX -> IDLE.
//  Timing:
//   - Start accepted in cycle T.
//   - busy=1 in cycles T+1..T+WIDTH+1 (WIDTH RUN cycles plus 1 FIX cycle).
//   - In cycle T+WIDTH+2: done=1, busy=0, and res shows the new HI/LO.
//   - A new start is legal in the same cycle as done.
//  Signed ops (mult, div):
//   - The datapath operates on magnitudes, with the sign applied in FIX.
//   - mult: {HI,LO} = full 2*WIDTH product.
//   - div: LO = quotient truncated toward zero; HI = remainder, carrying the sign of the dividend.
//   - Overflow: MIN/-1 gives LO=MIN, HI=0; no trap.
//  Divide by zero (div and divu): LO = all ones, HI = src_a as captured; normal latency, done still pulses.
//  start while busy=1 is ignored: no capture, no HI/LO write.
//  abort=1 in RUN or FIX -> IDLE next cycle:
//   - busy=0, no done, HI/LO keep their pre-op values.
//   - abort in IDLE has no effect; abort together with start in IDLE blocks the start.
//  res during busy returns the old HI/LO. Operand inputs may change after the start cycle.
// TESTING
//  (all WIDTH=32 unless stated)
//  1) mult -3 * 5: busy for 33 cycles, done at T+34, HI=FFFFFFFF, LO=FFFFFFF1.
//  2) multu FFFFFFFF * FFFFFFFF gives HI=FFFFFFFE, LO=00000001.
//  3) div -7 / 2 gives LO=FFFFFFFD, HI=FFFFFFFF.
//  4) div 80000000 / FFFFFFFF gives LO=80000000, HI=0.
//  5) divu 1234 / 0 gives LO=FFFFFFFF, HI=00001234.
//  6) mthi 5 then mtlo 6 then mfhi and mflo gives res=5 then res=6; no busy.
//  7) mult started, start with a new op at T+5 -> ignored.
//     Then abort at T+10 -> busy=0 at T+11, no done, HI/LO unchanged.
//  8) rst_n=0 at T+20 of a div -> HI=LO=0, busy=0, done=0.
//  9) WIDTH=8, div 0x81 / 0x03 -> LO=0xD6, HI=0xFF, done at T+10.
//     Then a back-to-back start on the done cycle is accepted.

Source files
------------

// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// Implements mult, multu, div, divu, mfhi, mthi, mflo and mtlo.
// Each mult/div step handles one operand bit per cycle. A final FIX cycle applies the sign correction.
//
// Ports:
//   clk    - rising-edge clock
//   rst_n  - synchronous active-low reset
//   start  - issue op; accepted only when idle
//   op     - 000 mult, 001 multu, 010 div, 011 divu, 100 mfhi, 101 mthi, 110 mflo, 111 mtlo
//   src_a  - dividend / multiplicand / mthi-mtlo data
//   src_b  - divisor / multiplier
//   abort  - kill an in-flight mult/div without touching HI/LO
//   busy   - mult/div in progress
//   done   - one-cycle pulse after HI/LO were written by a mult/div
//   res    - op[1] ? LO : HI
module mdu_iter #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] res
);

  typedef enum logic [1:0] {StIdle, StRun, StFix} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  // rem: partial remainder (div) or upper product half (mult).
  // quo: dividend shifting into quotient (div) or multiplier shifting into lower product (mult).
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic             is_div_q, is_div_d;
  logic             neg_q_q, neg_q_d;  // negate product / quotient
  logic             neg_r_q, neg_r_d;  // negate remainder
  logic             dz_q, dz_d;        // divide by zero
  logic             done_q, done_d;

  // Operand magnitudes for the start cycle
  logic             sgn, a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;

  // Step datapath
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH-1:0] prod;

  always_comb begin
    sgn   = ~op[0];
    a_neg = sgn & src_a[WIDTH-1];
    b_neg = sgn & src_b[WIDTH-1];
    a_mag = a_neg ? (~src_a + 1'b1) : src_a;
    b_mag = b_neg ? (~src_b + 1'b1) : src_b;

    mul_sum   = {1'b0, rem_q} + (quo_q[0] ? {1'b0, mcand_q} : '0);
    div_shift = {rem_q, quo_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, mcand_q};
    prod      = neg_q_q ? (~{rem_q, quo_q} + 1'b1) : {rem_q, quo_q};
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    mcand_d  = mcand_q;
    is_div_d = is_div_q;
    neg_q_d  = neg_q_q;
    neg_r_d  = neg_r_q;
    dz_d     = dz_q;
    done_d   = 1'b0;

    case (state_q)
      StIdle: begin
        // abort in the same cycle blocks the start
        if (start && !abort) begin
          if (!op[2]) begin
            is_div_d = op[1];
            neg_q_d  = a_neg ^ b_neg;
            neg_r_d  = a_neg;
            dz_d     = (src_b == '0);
            rem_d    = '0;
            quo_d    = op[1] ? a_mag : b_mag;
            mcand_d  = op[1] ? b_mag : a_mag;
            cnt_d    = CNT_W'(WIDTH);
            state_d  = StRun;
          end else if (op == 3'b101) begin
            hi_d = src_a;
          end else if (op == 3'b111) begin
            lo_d = src_a;
          end
        end
      end
      StRun: begin
        if (abort) begin
          state_d = StIdle;
        end else begin
          if (is_div_q) begin
            // Restoring division: keep the difference only when no borrow
            if (!div_diff[WIDTH]) begin
              rem_d = div_diff[WIDTH-1:0];
            end else begin
              rem_d = div_shift[WIDTH-1:0];
            end
            quo_d = {quo_q[WIDTH-2:0], ~div_diff[WIDTH]};
          end else begin
            rem_d = mul_sum[WIDTH:1];
            quo_d = {mul_sum[0], quo_q[WIDTH-1:1]};
          end
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) begin
            state_d = StFix;
          end
        end
      end
      StFix: begin
        state_d = StIdle;
        if (!abort) begin
          done_d = 1'b1;
          if (is_div_q) begin
            // Magnitude path already leaves |a| in rem for a zero divisor, so HI = src_a after sign fix
            lo_d = dz_q ? '1 : (neg_q_q ? (~quo_q + 1'b1) : quo_q);
            hi_d = neg_r_q ? (~rem_q + 1'b1) : rem_q;
          end else begin
            {hi_d, lo_d} = prod;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      mcand_q  <= '0;
      is_div_q <= 1'b0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      dz_q     <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      mcand_q  <= mcand_d;
      is_div_q <= is_div_d;
      neg_q_q  <= neg_q_d;
      neg_r_q  <= neg_r_d;
      dz_q     <= dz_d;
      done_q   <= done_d;
    end
  end

  assign busy = (state_q != StIdle);
  assign done = done_q;
  assign res  = op[1] ? lo_q : hi_q;

endmodule
